// File: rtl/datagraph_reduce_tree_if.sv
// Multi-lane producer / single-lane consumer handshake bundle for the reduction tree.
// master = producer+consumer side, slave = tree side.
interface datagraph_reduce_tree_if #(
    parameter int NUM_IN = 8,
    parameter int WIDTH  = 8,
    parameter int OUT_W  = 11
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/datagraph_reduce_tree.sv
// Pipelined binary reduction tree folding NUM_IN lanes into one result (ADD / XOR / MAX).
// Latency: LEVELS = $clog2(NUM_IN) cycles, one vector per cycle.
// Backpressure: bubble-collapsing per level; in_ready is combinational from out_ready.
module datagraph_reduce_tree #(
    parameter int  NUM_IN = 8,
    parameter int  WIDTH  = 8,
    parameter int  MODE   = 0,
    parameter int  CNT_W  = 16,
    localparam int LEVELS = $clog2(NUM_IN),
    localparam int OUT_W  = WIDTH + LEVELS
) (
    input  logic                   clk,
    input  logic                   rst,
    datagraph_reduce_tree_if.slave bus,
    output logic [CNT_W-1:0]       res_count
);

    // Bit offset of level lvl inside the flattened all-levels data vector.
    function automatic int lvl_off(input int lvl);
        int s;
        s = 0;
        for (int k = 0; k < lvl; k++) begin
            s += (NUM_IN >> k) * (WIDTH + k);
        end
        return s;
    endfunction

    localparam int TOT = lvl_off(LEVELS + 1);

    logic [TOT-1:0]      lvl_dat;
    logic [LEVELS:0]     lvl_vld;
    logic [LEVELS+1:1]   adv;
    logic                out_fire;
    logic [CNT_W-1:0]    res_cnt_q;
    logic [CNT_W-1:0]    res_cnt_d;

    assign lvl_dat[NUM_IN*WIDTH-1:0] = bus.in_data;
    assign lvl_vld[0]                = bus.in_valid;

    // A level may load when it is empty or the level ahead of it is moving.
    always_comb begin
        adv             = '0;
        adv[LEVELS+1]   = bus.out_ready;
        for (int l = LEVELS; l >= 1; l--) begin
            adv[l] = !lvl_vld[l] || adv[l+1];
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int N   = NUM_IN >> l;
        localparam int SW  = WIDTH + l - 1;
        localparam int DW  = WIDTH + l;
        localparam int SRC = lvl_off(l - 1);
        localparam int DST = lvl_off(l);

        logic [N*DW-1:0] dat_q;
        logic [N*DW-1:0] dat_d;
        logic            vld_q;

        for (genvar j = 0; j < N; j++) begin : g_node
            logic [SW-1:0] opa;
            logic [SW-1:0] opb;

            assign opa = lvl_dat[SRC + (2*j)*SW   +: SW];
            assign opb = lvl_dat[SRC + (2*j+1)*SW +: SW];

            if (MODE == 1) begin : g_xor
                assign dat_d[j*DW +: DW] = {1'b0, opa ^ opb};
            end else if (MODE == 2) begin : g_max
                assign dat_d[j*DW +: DW] = (opa > opb) ? {1'b0, opa} : {1'b0, opb};
            end else begin : g_add
                assign dat_d[j*DW +: DW] = {1'b0, opa} + {1'b0, opb};
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else if (adv[l]) begin
                vld_q <= lvl_vld[l-1];
                dat_q <= dat_d;
            end
        end

        assign lvl_dat[DST +: N*DW] = dat_q;
        assign lvl_vld[l]           = vld_q;
    end

    assign bus.in_ready  = adv[1];
    assign bus.out_valid = lvl_vld[LEVELS];
    assign bus.out_data  = lvl_dat[lvl_off(LEVELS) +: OUT_W];

    assign out_fire = lvl_vld[LEVELS] && bus.out_ready;

    always_comb begin
        res_cnt_d = res_cnt_q;
        if (out_fire) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt_q <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
        end
    end

    assign res_count = res_cnt_q;

endmodule
